// File: rtl/register_file_dumper.sv
// rtl/register_file_dumper.sv - debug reader that streams the 32x32 register file out, two registers per fetch
//
// Purpose:
//   On a start pulse, walks every architectural register through the register
//   file's two combinational read ports, one even/odd pair per FETCH cycle.
//   Each value is then presented as one beat on a valid/ready stream, tagged
//   with its register index. Each pair is captured atomically in its FETCH
//   cycle. There is no whole-file atomicity.
//
// Ports:
//   clk        in   1  clock, all state updates on posedge
//   rst        in   1  synchronous active-high reset, beats every other input
//   start      in   1  begin a dump, honoured only in IDLE
//   busy       out  1  high in FETCH, EMIT0 and EMIT1
//   done       out  1  one-cycle pulse after the last beat is accepted
//   rd_addr0   out  5  register-file read address, port 0 (= base)
//   rd_addr1   out  5  register-file read address, port 1 (= base+1)
//   rd_data0   in  32  register-file read data, port 0
//   rd_data1   in  32  register-file read data, port 1
//   out_valid  out  1  beat presented
//   out_ready  in   1  consumer accepts the beat
//   out_data   out 32  register value
//   out_addr   out  5  register index
//   out_last   out  1  high on the beat for register N_REGS-1 only
//
// N_REGS must be even and at most 32.

module register_file_dumper #(
  parameter int N_REGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rd_addr0,
  output logic [4:0]  rd_addr1,
  input  logic [31:0] rd_data0,
  input  logic [31:0] rd_data1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_addr,
  output logic        out_last
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EMIT0,
    S_EMIT1,
    S_DONE
  } state_t;

  // Base of the final pair. The odd register of this pair is the last beat.
  localparam logic [4:0] LAST_BASE = 5'(N_REGS - 2);

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  base;
  logic [4:0]  base_nxt;
  logic [31:0] buf0;
  logic [31:0] buf1;

  // Output tag registers. They are loaded only when a new beat becomes
  // current. As a result, address, last and data selection hold their
  // previous values outside EMIT0/EMIT1 and stay stable under backpressure.
  logic        sel_q;   // 0: buf0 is current, 1: buf1 is current
  logic [4:0]  addr_q;
  logic        last_q;

  // base is always even, so OR-ing in bit 0 gives base+1 without an adder.
  assign rd_addr0 = base;
  assign rd_addr1 = base | 5'd1;

  assign out_data = sel_q ? buf1 : buf0;
  assign out_addr = addr_q;
  assign out_last = last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      base   <= 5'd0;
      buf0   <= 32'd0;
      buf1   <= 32'd0;
      sel_q  <= 1'b0;
      addr_q <= 5'd0;
      last_q <= 1'b0;
    end else begin
      state <= state_nxt;
      base  <= base_nxt;

      // Atomic pair capture. The even register becomes the current beat.
      if (state == S_FETCH) begin
        buf0   <= rd_data0;
        buf1   <= rd_data1;
        sel_q  <= 1'b0;
        addr_q <= base;
        last_q <= 1'b0;
      end

      // The even beat is accepted, so the odd beat of the same pair becomes current.
      if (state == S_EMIT0 && out_ready) begin
        sel_q  <= 1'b1;
        addr_q <= base | 5'd1;
        last_q <= (base == LAST_BASE);
      end
    end
  end

  // out_valid is a pure function of state. It never looks at out_ready.
  always_comb begin
    state_nxt = state;
    base_nxt  = base;
    busy      = 1'b0;
    done      = 1'b0;
    out_valid = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          base_nxt  = 5'd0;
          state_nxt = S_FETCH;
        end
      end

      S_FETCH: begin
        busy      = 1'b1;
        state_nxt = S_EMIT0;
      end

      S_EMIT0: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = S_EMIT1;
        end
      end

      S_EMIT1: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          if (base == LAST_BASE) begin
            state_nxt = S_DONE;
          end else begin
            base_nxt  = base + 5'd2;
            state_nxt = S_FETCH;
          end
        end
      end

      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_register_file_dumper.sv
// tb/tb_register_file_dumper.sv - self-checking bench for register_file_dumper
//
// Purpose:
//   Models the register file as a plain array with combinational reads.
//   Expected dump contents are derived from the snapshot rule: a write is
//   visible iff it lands before its pair's fetch. Stall-adjusted timing is
//   derived from the cycle rules.
//
// Ports: none (top-level bench).

module tb_register_file_dumper;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        out_valid;
  logic        out_last;
  logic [4:0]  rd_addr0;
  logic [4:0]  rd_addr1;
  logic [4:0]  out_addr;
  logic [31:0] rd_data0;
  logic [31:0] rd_data1;
  logic [31:0] out_data;

  logic [31:0] rf [N];
  logic [31:0] exp_v [N];

  int          errors = 0;
  int          checks = 0;

  // Write schedule: register wr_reg gets wr_val when beat wr_trig is first presented.
  int          wr_n;
  int          wr_trig [4];
  int          wr_reg [4];
  logic [31:0] wr_val [4];
  bit          wr_fired [4];

  typedef struct {
    int mode;            // 0: ready always, 1: stall on addr 7 then toggle, 2: random
    bit extra_start;     // extra start pulse at t+10
    int wset;            // 0: no writes, 1: x3 after its fetch, x20 before its fetch
    int exp_beats;
    int exp_done_base;   // done cycle relative to start with no stalls
  } vec_t;

  vec_t tbl [5];

  always #5 clk = ~clk;

  // The register file guarantees that x0 reads zero.
  assign rd_data0 = (rd_addr0 == 5'd0) ? 32'd0 : rf[rd_addr0];
  assign rd_data1 = (rd_addr1 == 5'd0) ? 32'd0 : rf[rd_addr1];

  register_file_dumper #(.N_REGS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_addr0  (rd_addr0),
    .rd_addr1  (rd_addr1),
    .rd_data0  (rd_data0),
    .rd_data1  (rd_data1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_last  (out_last)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Snapshot rule. A write triggered while beat a is presented lands before
  // the fetch of the pair at base b iff a < b.
  function automatic void build_expected();
    for (int i = 0; i < N; i++) begin
      logic [31:0] v;
      v = (i == 0) ? 32'd0 : rf[i];
      for (int w = 0; w < wr_n; w++) begin
        if (wr_reg[w] == i && wr_trig[w] < 2 * (i / 2)) v = wr_val[w];
      end
      exp_v[i] = v;
    end
  endfunction

  task automatic run_dump(input int mode, input bit extra_start, input int abort_beat,
                          input int exp_beats, input int exp_done_base);
    int          beats;
    int          stalls;
    int          done_cyc;
    int          stall7;
    bit          tgl;
    bit          prev_stall;
    bit          do_abort;
    logic [31:0] prev_data;
    logic [4:0]  prev_addr;
    logic        prev_last;
    logic        exp_busy;
    logic        exp_done;

    build_expected();
    beats = 0;
    stalls = 0;
    done_cyc = -1;
    stall7 = 0;
    tgl = 1'b0;
    prev_stall = 1'b0;
    do_abort = 1'b0;
    prev_data = '0;
    prev_addr = '0;
    prev_last = 1'b0;
    for (int w = 0; w < wr_n; w++) wr_fired[w] = 1'b0;

    for (int c = 0; c < 400; c++) begin
      start = (c == 0) || (extra_start && c == 10);
      case (mode)
        0: out_ready = 1'b1;
        1: begin
          if (out_valid && out_addr == 5'd7 && stall7 < 5) begin
            out_ready = 1'b0;
            stall7++;
          end else if (stall7 == 5) begin
            out_ready = ~tgl;
            tgl = ~tgl;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase

      if (out_valid) begin
        for (int w = 0; w < wr_n; w++) begin
          if (!wr_fired[w] && out_addr == 5'(wr_trig[w])) begin
            rf[wr_reg[w]] = wr_val[w];
            wr_fired[w] = 1'b1;
          end
        end
      end

      exp_busy = (c >= 1) && (c < exp_done_base + stalls);
      exp_done = (c == exp_done_base + stalls);
      check($sformatf("busy@%0d", c), 32'(busy), 32'(exp_busy));
      check($sformatf("done@%0d", c), 32'(done), 32'(exp_done));

      if (out_valid && beats < N) begin
        check($sformatf("addr[%0d]", beats), 32'(out_addr), 32'(beats));
        check($sformatf("data[%0d]", beats), out_data, exp_v[beats]);
        check($sformatf("last[%0d]", beats), 32'(out_last), 32'(beats == N - 1));
      end
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", out_data, prev_data);
        check("stall_addr", 32'(out_addr), 32'(prev_addr));
        check("stall_last", 32'(out_last), 32'(prev_last));
      end

      if (out_valid && !out_ready) stalls++;
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      prev_addr = out_addr;
      prev_last = out_last;
      if (out_valid && out_ready) begin
        beats++;
        if (beats - 1 == abort_beat) do_abort = 1'b1;
      end
      if (done) done_cyc = c;

      step();

      if (do_abort) begin
        start = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        return;
      end
      if (done_cyc >= 0) begin
        start = 1'b0;
        check("post_busy", 32'(busy), 32'd0);
        check("post_valid", 32'(out_valid), 32'd0);
        check("post_done", 32'(done), 32'd0);
        break;
      end
    end
    start = 1'b0;
    check("beat_count", 32'(beats), 32'(exp_beats));
    check("done_cycle", 32'(done_cyc), 32'(exp_done_base + stalls));
  endtask

  initial begin
    tbl[0] = '{mode: 0, extra_start: 1'b0, wset: 0, exp_beats: 32, exp_done_base: 49};
    tbl[1] = '{mode: 0, extra_start: 1'b1, wset: 0, exp_beats: 32, exp_done_base: 49};
    tbl[2] = '{mode: 0, extra_start: 1'b0, wset: 0, exp_beats: 32, exp_done_base: 49};
    tbl[3] = '{mode: 1, extra_start: 1'b0, wset: 0, exp_beats: 32, exp_done_base: 49};
    tbl[4] = '{mode: 0, extra_start: 1'b0, wset: 1, exp_beats: 32, exp_done_base: 49};

    for (int i = 0; i < N; i++) rf[i] = 32'hA5A5_0000 + 32'(i);
    rf[0] = 32'd0;
    wr_n = 0;

    // Reset held for two cycles with start high.
    rst = 1'b1;
    start = 1'b1;
    out_ready = 1'b1;
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_addr", 32'(out_addr), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_rd_addr0", 32'(rd_addr0), 32'd0);
    check("rst_rd_addr1", 32'(rd_addr1), 32'd1);
    step();
    rst = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("no_dump_busy", 32'(busy), 32'd0);
      check("no_dump_valid", 32'(out_valid), 32'd0);
    end

    // Table rows run back to back. Each starts in the IDLE cycle at t+50 of the previous one.
    for (int r = 0; r < 5; r++) begin
      wr_n = 0;
      if (tbl[r].wset == 1) begin
        wr_n = 2;
        wr_trig[0] = 2;  wr_reg[0] = 3;  wr_val[0] = 32'hDEAD_BEEF;
        wr_trig[1] = 5;  wr_reg[1] = 20; wr_val[1] = 32'hCAFE_F00D;
      end
      run_dump(tbl[r].mode, tbl[r].extra_start, -1, tbl[r].exp_beats, tbl[r].exp_done_base);
    end
    check("x3_kept_write", rf[3], 32'hDEAD_BEEF);

    // Reset right after beat 10 is accepted, then verify nothing resumes.
    wr_n = 0;
    run_dump(0, 1'b0, 10, 32, 49);
    for (int i = 0; i < 60; i++) begin
      check("abandon_done", 32'(done), 32'd0);
      check("abandon_valid", 32'(out_valid), 32'd0);
      step();
    end
    run_dump(0, 1'b0, -1, 32, 49);

    // Random contents, random backpressure, random writes during the dump.
    for (int r = 0; r < 4; r++) begin
      int r1;
      for (int i = 1; i < N; i++) rf[i] = $urandom;
      r1 = $urandom_range(1, 31);
      wr_n = 2;
      wr_reg[0] = r1;
      wr_reg[1] = (r1 % 31) + 1;
      wr_trig[0] = $urandom_range(0, 31);
      wr_trig[1] = $urandom_range(0, 31);
      wr_val[0] = $urandom;
      wr_val[1] = $urandom;
      run_dump(2, 1'b0, -1, 32, 49);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
